// File: rtl/disp_pkg.sv
// Shared constants and types for the seven-segment scan path.
package disp_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned SCAN_W     = 3;
  localparam int unsigned HEX_W      = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    BLANK
  } state_e;

  localparam logic [HEX_W-1:0]      HEXS_RST  = '0;
  localparam logic [NUM_DIGITS-1:0] POINT_RST = '0;
  localparam logic [NUM_DIGITS-1:0] LES_RST   = '0;

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Bundle between the CPU-side display register / scan mux and the scan sequencer.
interface disp_scan_ctrl_if;
  import disp_pkg::*;

  logic                  en;
  logic [HEX_W-1:0]      data_in;
  logic [NUM_DIGITS-1:0] point_in;
  logic [NUM_DIGITS-1:0] les_in;
  logic                  upd_req;
  logic                  upd_busy;
  logic                  upd_ack;
  logic [SCAN_W-1:0]     scan;
  logic [HEX_W-1:0]      hexs;
  logic [NUM_DIGITS-1:0] point;
  logic [NUM_DIGITS-1:0] les;
  logic                  blank;
  logic                  frame_tick;

  modport master (
    output en, data_in, point_in, les_in, upd_req,
    input  upd_busy, upd_ack, scan, hexs, point, les, blank, frame_tick
  );

  modport slave (
    input  en, data_in, point_in, les_in, upd_req,
    output upd_busy, upd_ack, scan, hexs, point, les, blank, frame_tick
  );

endinterface

// File: rtl/disp_phase_timer.sv
// Phase counter shared by the SHOW and BLANK phases; done fires on the terminal count.
module disp_phase_timer #(
  parameter int unsigned CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run_i,
  input  logic          clr_i,
  input  logic [CW-1:0] term_i,
  output logic          done_o
);

  logic [CW-1:0] cnt_q;

  assign done_o = run_i && (cnt_q == term_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i || done_o) begin
      cnt_q <= '0;
    end else if (run_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Digit scan sequencer with show/blank phases and frame-synchronous double-buffered display data.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES  = 50000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input logic             clk,
  input logic             rst_n,
  disp_scan_ctrl_if.slave bus
);

  localparam int unsigned CNT_MAX =
    (SHOW_CYCLES > BLANK_CYCLES) ? ((SHOW_CYCLES > 2) ? SHOW_CYCLES : 2)
                                 : ((BLANK_CYCLES > 2) ? BLANK_CYCLES : 2);
  localparam int unsigned CW        = $clog2(CNT_MAX);
  localparam bit          HAS_BLANK = (BLANK_CYCLES != 0);
  localparam logic [CW-1:0]     SHOW_TERM  = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0]     BLANK_TERM = CW'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);
  localparam logic [SCAN_W-1:0] LAST_DIGIT = SCAN_W'(NUM_DIGITS - 1);

  state_e                state_q;
  logic [SCAN_W-1:0]     scan_q;
  logic                  blank_q;
  logic                  frame_tick_q;
  logic                  upd_ack_q;
  logic                  upd_busy_q;
  logic [HEX_W-1:0]      stg_hex_q, hexs_q;
  logic [NUM_DIGITS-1:0] stg_pt_q, point_q;
  logic [NUM_DIGITS-1:0] stg_le_q, les_q;

  logic          tmr_run, tmr_clr, tmr_done;
  logic [CW-1:0] tmr_term;
  logic          adv, wrap, apply;

  // The timer keeps running while en is low so a wrap landing on the en-fall edge still completes.
  always_comb begin
    tmr_run  = (state_q != IDLE);
    tmr_clr  = (state_q == IDLE) || !bus.en;
    tmr_term = (state_q == BLANK) ? BLANK_TERM : SHOW_TERM;
    adv      = tmr_done && ((state_q == BLANK) || ((state_q == SHOW) && !HAS_BLANK));
    wrap     = adv && (scan_q == LAST_DIGIT);
    apply    = upd_busy_q && (wrap || (state_q == IDLE));
  end

  disp_phase_timer #(
    .CW(CW)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .run_i  (tmr_run),
    .clr_i  (tmr_clr),
    .term_i (tmr_term),
    .done_o (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      scan_q       <= '0;
      blank_q      <= 1'b1;
      frame_tick_q <= 1'b0;
      upd_ack_q    <= 1'b0;
      upd_busy_q   <= 1'b0;
      stg_hex_q    <= '0;
      stg_pt_q     <= '0;
      stg_le_q     <= '0;
      hexs_q       <= HEXS_RST;
      point_q      <= POINT_RST;
      les_q        <= LES_RST;
    end else begin
      frame_tick_q <= wrap;
      upd_ack_q    <= apply;

      // apply only fires while busy, so a same-cycle request can only be staged for the next wrap.
      if (apply) begin
        hexs_q     <= stg_hex_q;
        point_q    <= stg_pt_q;
        les_q      <= stg_le_q;
        upd_busy_q <= 1'b0;
      end else if (bus.upd_req && !upd_busy_q) begin
        stg_hex_q  <= bus.data_in;
        stg_pt_q   <= bus.point_in;
        stg_le_q   <= bus.les_in;
        upd_busy_q <= 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          scan_q <= '0;
          if (bus.en) begin
            state_q <= SHOW;
            blank_q <= 1'b0;
          end else begin
            blank_q <= 1'b1;
          end
        end
        SHOW, BLANK: begin
          if (adv) scan_q <= scan_q + 1'b1;
          if (!bus.en) begin
            state_q <= IDLE;
            scan_q  <= '0;
            blank_q <= 1'b1;
          end else if (tmr_done) begin
            if ((state_q == SHOW) && HAS_BLANK) begin
              state_q <= BLANK;
              blank_q <= 1'b1;
            end else begin
              state_q <= SHOW;
              blank_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.scan       = scan_q;
  assign bus.blank      = blank_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.upd_ack    = upd_ack_q;
  assign bus.upd_busy   = upd_busy_q;
  assign bus.hexs       = hexs_q;
  assign bus.point      = point_q;
  assign bus.les        = les_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl: position-based reference model feeding an expected-output queue.
module tb_disp_scan_ctrl;
  import disp_pkg::*;

  localparam int S = 4;
  localparam int B = 2;
  localparam int P = S + B;
  localparam int F = NUM_DIGITS * P;

  typedef struct packed {
    logic [2:0]  scan;
    logic        blank;
    logic        tick;
    logic        ack;
    logic        busy;
    logic [31:0] hexs;
    logic [7:0]  pt;
    logic [7:0]  le;
  } obs_t;

  typedef struct packed {
    logic [31:0] hexs;
    logic [7:0]  pt;
    logic [7:0]  le;
  } shd_t;

  localparam obs_t RST_VEC = '{scan: 3'd0, blank: 1'b1, tick: 1'b0, ack: 1'b0,
                               busy: 1'b0, hexs: 32'h0, pt: 8'h0, le: 8'h0};

  logic clk = 1'b0;
  logic rst_n, rst0_n;
  always #5 clk = ~clk;

  disp_scan_ctrl_if bif ();
  disp_scan_ctrl_if bif0 ();

  disp_scan_ctrl #(.SHOW_CYCLES(S), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif)
  );

  disp_scan_ctrl #(.SHOW_CYCLES(S), .BLANK_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .bus(bif0)
  );

  int   checks = 0;
  int   failures = 0;
  bit   seen_dead = 1'b0;
  bit   done0 = 1'b0;
  obs_t exp_q[$];
  shd_t ack_q[$];

  bit   m_run;
  int   m_pos;
  bit   m_busy;
  shd_t m_stg, m_shd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic obs_t sample();
    return '{scan: bif.scan, blank: bif.blank, tick: bif.frame_tick, ack: bif.upd_ack,
             busy: bif.upd_busy, hexs: bif.hexs, pt: bif.point, le: bif.les};
  endfunction

  // Reference model: the frame is a position 0..F-1 since SHOW entry; digit and phase follow by division.
  initial begin : model
    obs_t e;
    bit   tick, apply;
    m_run = 0; m_pos = 0; m_busy = 0; m_stg = '0; m_shd = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_run = 0; m_pos = 0; m_busy = 0; m_stg = '0; m_shd = '0;
        ack_q.delete();
        exp_q.push_back(RST_VEC);
      end else begin
        tick = 0;
        apply = 0;
        if (m_run) begin
          tick  = (m_pos == F - 1);
          apply = tick && m_busy;
          if (!bif.en) m_run = 0;
          else m_pos = (m_pos + 1) % F;
        end else begin
          apply = m_busy;
          if (bif.en) begin
            m_run = 1;
            m_pos = 0;
          end
        end
        if (apply) begin
          m_shd  = m_stg;
          m_busy = 0;
        end else if (bif.upd_req && !m_busy) begin
          m_stg  = '{hexs: bif.data_in, pt: bif.point_in, le: bif.les_in};
          m_busy = 1;
          ack_q.push_back(m_stg);
        end
        e.scan  = m_run ? 3'(m_pos / P) : 3'd0;
        e.blank = m_run ? ((m_pos % P) >= S) : 1'b1;
        e.tick  = tick;
        e.ack   = apply;
        e.busy  = m_busy;
        e.hexs  = m_shd.hexs;
        e.pt    = m_shd.pt;
        e.le    = m_shd.le;
        exp_q.push_back(e);
      end
    end
  end

  initial begin : monitor
    obs_t a, e;
    shd_t s;
    forever begin
      @(negedge clk);
      a = sample();
      if (a.hexs == 32'hDEADBEEF) seen_dead = 1'b1;
      if (!rst_n) begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check("reset_state", a, RST_VEC);
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle_outputs", a, e);
        if (a.ack) begin
          if (ack_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack actual=1 required=0");
          end else begin
            s = ack_q.pop_front();
            check("ack_shadows", {a.hexs, a.pt, a.le}, s);
          end
        end
      end
    end
  end

  task automatic step(input bit en, input bit req, input logic [31:0] d,
                      input logic [7:0] p, input logic [7:0] l);
    bif.en = en; bif.upd_req = req; bif.data_in = d; bif.point_in = p; bif.les_in = l;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_pos(input int pos, input bit need_busy);
    int n = 0;
    while (!(m_run && m_pos == pos && (!need_busy || m_busy)) && n < 400) begin
      step(1, 0, '0, '0, '0);
      n++;
    end
    if (n >= 400) begin
      checks++;
      failures++;
      $display("FAIL wait_pos actual=timeout required=pos%0d", pos);
    end
  endtask

  initial begin : drive
    int n;
    bit en_r;
    rst_n = 1'b0;
    bif.en = 0; bif.upd_req = 0; bif.data_in = '0; bif.point_in = '0; bif.les_in = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step(0, 0, '0, '0, '0);

    step(1, 0, '0, '0, '0);
    check("show_entry", {bif.scan, bif.blank}, {3'd0, 1'b0});
    n = 0;
    while (!bif.frame_tick && n < 100) begin
      step(1, 0, '0, '0, '0);
      n++;
    end
    check("first_tick_latency", n, 48);

    repeat (20) step(1, 0, '0, '0, '0);
    step(1, 1, 32'h12345678, 8'h0F, 8'hA5);
    check("busy_after_req", bif.upd_busy, 1'b1);
    check("hexs_before_wrap", bif.hexs, 32'h0);
    repeat (3) step(1, 0, '0, '0, '0);
    step(1, 1, 32'hDEADBEEF, 8'hFF, 8'hFF);
    n = 0;
    while (!bif.upd_ack && n < 100) begin
      step(1, 0, '0, '0, '0);
      n++;
    end
    check("apply_values", {bif.hexs, bif.point, bif.les, bif.frame_tick},
          {32'h12345678, 8'h0F, 8'hA5, 1'b1});
    repeat (10) step(1, 0, '0, '0, '0);
    check("busy_req_ignored", seen_dead, 1'b0);

    run_until_pos(F - 1, 0);
    step(1, 1, 32'hCAFEF00D, 8'h3C, 8'h5A);
    check("wrap_req_not_applied", {bif.frame_tick, bif.upd_ack, bif.upd_busy, bif.hexs},
          {1'b1, 1'b0, 1'b1, 32'h12345678});
    repeat (F - 1) step(1, 0, '0, '0, '0);
    check("wrap_req_held", bif.hexs, 32'h12345678);
    step(1, 0, '0, '0, '0);
    check("wrap_req_next_frame", {bif.upd_ack, bif.hexs, bif.point, bif.les},
          {1'b1, 32'hCAFEF00D, 8'h3C, 8'h5A});

    run_until_pos(3 * P + S, 0);
    step(0, 0, '0, '0, '0);
    check("en_drop_idle", {bif.scan, bif.blank}, {3'd0, 1'b1});
    repeat (4) step(0, 0, '0, '0, '0);
    step(1, 0, '0, '0, '0);
    check("restart_show", {bif.scan, bif.blank}, {3'd0, 1'b0});
    repeat (S) step(1, 0, '0, '0, '0);
    check("restart_full_show", {bif.scan, bif.blank}, {3'd0, 1'b1});

    en_r = 1;
    repeat (600) begin
      if ($urandom_range(99) == 0) en_r = !en_r;
      step(en_r, ($urandom_range(7) == 0), $urandom, 8'($urandom), 8'($urandom));
    end

    run_until_pos(0, 0);
    step(1, 1, 32'h11112222, 8'h33, 8'h44);
    run_until_pos(P + 1, 1);
    rst_n = 1'b0;
    #2;
    check("async_reset", sample(), RST_VEC);
    repeat (2) step(0, 0, '0, '0, '0);
    rst_n = 1'b1;
    repeat (2) step(0, 0, '0, '0, '0);
    repeat (F + 10) step(1, 0, '0, '0, '0);
    check("staging_cleared", {bif.hexs, bif.upd_busy}, {32'h0, 1'b0});
    repeat (3) step(0, 0, '0, '0, '0);

    n = 0;
    while (!done0 && n < 500) begin
      step(0, 0, '0, '0, '0);
      n++;
    end
    check("noblank_done", done0, 1'b1);
    check("ack_drain", ack_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Zero-blank variant: digits advance straight from SHOW and blank stays low while scanning.
  initial begin : noblank
    rst0_n = 1'b0;
    bif0.en = 0; bif0.upd_req = 0; bif0.data_in = '0; bif0.point_in = '0; bif0.les_in = '0;
    repeat (3) @(posedge clk);
    #1 rst0_n = 1'b1;
    @(negedge clk);
    check("b0_reset", {bif0.scan, bif0.blank, bif0.frame_tick}, {3'd0, 1'b1, 1'b0});
    @(posedge clk);
    #1 bif0.en = 1;
    @(posedge clk);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      check("b0_scan", {bif0.scan, bif0.blank, bif0.frame_tick},
            {3'((k / S) % 8), 1'b0, 1'(k > 0 && k % (8 * S) == 0)});
    end
    done0 = 1'b1;
  end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Scan sequencer for the eight-digit seven-segment display path. It drives the 3-bit digit index consumed by the scan multiplexer, with a timed show/blank phase per digit to suppress ghosting. It holds a double-buffered copy of the 32-bit hex word, the decimal-point mask and the LE mask, so that updates only take effect on frame boundaries. It sits directly upstream of the scan mux and is fed by the CPU-side display register.

## Interface
Parameters:
- SHOW_CYCLES, 50000, cycles each digit is driven; must be ≥1.
- BLANK_CYCLES, 1000, cycles of forced blanking after each digit; 0 disables the blank phase.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  scanning enable; 0 holds the display blanked.
- data_in  input  32  new hex word, eight nibbles, nibble k = digit k.
- point_in  input  8  new decimal-point mask, bit k = digit k.
- les_in  input  8  new LE mask, bit k = digit k.
- upd_req  input  1  level request to stage data_in, point_in and les_in.
- upd_busy  output  1  staged update pending; upd_req ignored while high.
- upd_ack  output  1  one-cycle pulse when the staged update becomes visible.
- scan  output  3  current digit index, to the scan mux.
- hexs  output  32  displayed hex word, registered shadow.
- point  output  8  displayed point mask, registered shadow.
- les  output  8  displayed LE mask, registered shadow.
- blank  output  1  1 = downstream must force all anodes off.
- frame_tick  output  1  one-cycle pulse at each frame start.

## Operation
- The state machine has three states: IDLE, SHOW and BLANK.
- IDLE:
  - Outputs: blank=1, scan=0, phase counter 0.
  - Transition: en=1 → SHOW.
- SHOW:
  - Outputs: blank=0; the phase counter counts 0..SHOW_CYCLES-1.
  - At terminal count with BLANK_CYCLES>0 → BLANK.
  - At terminal count with BLANK_CYCLES=0 → advance digit, stay in SHOW.
- BLANK:
  - Outputs: blank=1; counts 0..BLANK_CYCLES-1.
  - At terminal count → advance digit, then SHOW.
- Advance digit: scan increments modulo 8. On the 7→0 wrap:
  - frame_tick=1 for that cycle.
  - If upd_busy=1: copy staging into the shadows, clear upd_busy, and pulse upd_ack, all in the same cycle.
- Staging:
  - If upd_req=1 and upd_busy=0, then data_in, point_in and les_in are captured into staging registers and upd_busy is set on the next cycle.
  - upd_req while busy has no effect.
- In IDLE, a pending update is applied on the next cycle, with upd_ack pulsed and frame_tick not pulsed.
- en=0 in SHOW or BLANK → next cycle IDLE, scan=0, counter cleared. Pending staging is retained.
- Simultaneous events:
  - If upd_req with busy=0 lands in the wrap cycle, it is staged only. It is applied at the following wrap, never at the same one.
  - en falling in the wrap cycle: the wrap actions (tick, apply) complete, then the block enters IDLE.
- Counter width is clog2 of max(SHOW_CYCLES, BLANK_CYCLES, 2). Comparisons are against parameter-1 and never overflow.

## Timing
- Reset values:
  - State: IDLE.
  - Data outputs: scan=0, hexs=0, point=0, les=0.
  - Status outputs: blank=1, frame_tick=0, upd_ack=0, upd_busy=0.
  - Internal: staging=0, counter=0.
- Reset assertion mid-frame takes effect immediately (asynchronous). Reset release resumes from IDLE.
- en rising at cycle t → SHOW at t+1 with scan=0 and blank=0. No frame_tick is pulsed for the first frame.
- Digit period is SHOW_CYCLES+BLANK_CYCLES cycles. Frame period is 8× that.
- The scan change, blank deassertion, shadow update and frame_tick are all registered outputs. They change together on the same edge.
- Update latency: upd_req sampled at t → upd_busy at t+1 → visible at the next wrap (at most one frame + 1 cycle).

## Structure
- Shared package disp_pkg holds:
  - NUM_DIGITS=8 and SCAN_W=3.
  - The state enum: IDLE, SHOW, BLANK.
  - Reset constants for the shadows.
- Sub-module disp_phase_timer holds the phase counter. It is loadable with a terminal value and outputs a done pulse. It is reused for the SHOW and BLANK phases.

## Test plan
Each scenario runs with SHOW_CYCLES=4 and BLANK_CYCLES=2.
- Reset, then en=1: scan runs 0,1,…,7,0. Each digit gives 4 cycles of blank=0 followed by 2 cycles of blank=1. The first frame_tick occurs 48 cycles after SHOW entry.
- upd_req for one cycle with data_in=0x12345678, point_in=0x0F and les_in=0xA5 mid-frame: upd_busy=1 on the next cycle. hexs stays 0 until the wrap, then hexs=0x12345678, point=0x0F and les=0xA5, with upd_ack and frame_tick in the same cycle.
- Second upd_req (data_in=0xDEADBEEF) while busy: ignored. The first value is applied and 0xDEADBEEF never appears.
- upd_req in the exact wrap cycle with busy=0: not applied at that wrap, applied at the next one, 48 cycles later.
- en dropped at scan=3 in BLANK: next cycle IDLE, blank=1, scan=0. On en re-raise the scan restarts at 0 with a full SHOW phase.
- rst_n pulsed low mid-SHOW with busy=1: all outputs return to their reset values immediately and the staging is cleared. With BLANK_CYCLES=0 the blank output is never asserted while en=1.
